// File: rtl/lstm_pf_pkg.sv
// rtl/lstm_pf_pkg.sv - shared fixed-point types and prefetch FSM states
// Reused by the dense layer; logits are signed Q(QN).(QM).
package lstm_pf_pkg;

   localparam int QN       = 6;
   localparam int QM       = 11;
   localparam int BITWIDTH = QN + QM + 1;

   typedef logic signed [BITWIDTH-1:0] logit_t;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      HOLD,
      FALLBACK,
      DONE
   } pf_state_e;

endpackage

// File: rtl/pf_logit_mux.sv
// rtl/pf_logit_mux.sv - selects one logit from the registered dense vector
// Purely combinational; the caller owns the index register.
module pf_logit_mux
   import lstm_pf_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N*BITWIDTH-1:0]  vec,
   input  logic [$clog2(N)-1:0]   idx,
   output logit_t                 logit
);

   logit_t lane [N];

   for (genvar g = 0; g < N; g++) begin : g_lane
      assign lane[g] = vec[g*BITWIDTH +: BITWIDTH];
   end

   assign logit = lane[idx];

endmodule

// File: rtl/prefetch_select.sv
// rtl/prefetch_select.sv - serial threshold scan of dense logits into prefetch candidates
// Optional ARGMAX_FALLBACK_EN: a zero-hit vector emits its argmax as a single candidate.
module prefetch_select
   import lstm_pf_pkg::*;
#(
   parameter int FINAL_OUT_SIZE = 16,
   parameter int MAX_PF         = 4
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [FINAL_OUT_SIZE*BITWIDTH-1:0]   outputVec,
   input  logic                                 data_result_Ready,
   input  logic [BITWIDTH-1:0]                  threshold,
   output logic                                 pf_valid,
   input  logic                                 pf_ready,
   output logic [$clog2(FINAL_OUT_SIZE)-1:0]    pf_index,
   output logic [BITWIDTH-1:0]                  pf_score,
   output logic                                 done,
   output logic [$clog2(MAX_PF+1)-1:0]          pf_count,
   output logic [$clog2(FINAL_OUT_SIZE)-1:0]    argmax_index,
   output logic                                 overrun
);

   localparam int IW = $clog2(FINAL_OUT_SIZE);
   localparam int CW = $clog2(MAX_PF + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(FINAL_OUT_SIZE - 1);
   localparam logic [CW-1:0] CAP      = CW'(MAX_PF);

   pf_state_e                          state_q, state_d;
   logic                               rdy_q, rdy_d;
   logic [FINAL_OUT_SIZE*BITWIDTH-1:0] vec_q, vec_d;
   logit_t                             thr_q, thr_d;
   logic [IW-1:0]                      idx_q, idx_d;
   logic [CW-1:0]                      cnt_q, cnt_d;
   logit_t                             max_q, max_d;
   logic [IW-1:0]                      argidx_q, argidx_d;
   logic                               pf_valid_q, pf_valid_d;
   logic [IW-1:0]                      pf_index_q, pf_index_d;
   logit_t                             pf_score_q, pf_score_d;
   logic                               done_q, done_d;
   logic [CW-1:0]                      pf_count_q, pf_count_d;
   logic [IW-1:0]                      argmax_q, argmax_d;
   logic                               overrun_q, overrun_d;

   logit_t cur_logit;
   logic   rise;

   pf_logit_mux #(.N(FINAL_OUT_SIZE)) u_logit_mux (
      .vec   (vec_q),
      .idx   (idx_q),
      .logit (cur_logit)
   );

   assign rise = data_result_Ready & ~rdy_q;

   always_comb begin
      state_d    = state_q;
      rdy_d      = data_result_Ready;
      vec_d      = vec_q;
      thr_d      = thr_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      max_d      = max_q;
      argidx_d   = argidx_q;
      pf_valid_d = pf_valid_q;
      pf_index_d = pf_index_q;
      pf_score_d = pf_score_q;
      done_d     = 1'b0;
      pf_count_d = pf_count_q;
      argmax_d   = argmax_q;
      overrun_d  = rise && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (rise) begin
               vec_d    = outputVec;
               thr_d    = threshold;
               idx_d    = '0;
               cnt_d    = '0;
               max_d    = outputVec[BITWIDTH-1:0];
               argidx_d = '0;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            // strict compare keeps the lowest index on ties
            if (cur_logit > max_q) begin
               max_d    = cur_logit;
               argidx_d = idx_q;
            end
            if (cur_logit > thr_q) begin
               pf_valid_d = 1'b1;
               pf_index_d = idx_q;
               pf_score_d = cur_logit;
               state_d    = HOLD;
            end else if (idx_q == LAST_IDX) begin
               state_d = DONE;
`ifdef ARGMAX_FALLBACK_EN
               if (cnt_q == '0) begin
                  pf_valid_d = 1'b1;
                  pf_index_d = argidx_d;
                  pf_score_d = max_d;
                  state_d    = FALLBACK;
               end
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         HOLD: begin
            if (pf_valid_q && pf_ready) begin
               pf_valid_d = 1'b0;
               cnt_d      = cnt_q + 1'b1;
               if ((cnt_d == CAP) || (idx_q == LAST_IDX)) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = SCAN;
               end
            end
         end
`ifdef ARGMAX_FALLBACK_EN
         FALLBACK: begin
            if (pf_valid_q && pf_ready) begin
               pf_valid_d = 1'b0;
               cnt_d      = CW'(1);
               state_d    = DONE;
            end
         end
`endif
         DONE: begin
            done_d     = 1'b1;
            pf_count_d = cnt_q;
            argmax_d   = argidx_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rdy_q      <= 1'b0;
         vec_q      <= '0;
         thr_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         max_q      <= '0;
         argidx_q   <= '0;
         pf_valid_q <= 1'b0;
         pf_index_q <= '0;
         pf_score_q <= '0;
         done_q     <= 1'b0;
         pf_count_q <= '0;
         argmax_q   <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= rdy_d;
         vec_q      <= vec_d;
         thr_q      <= thr_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         max_q      <= max_d;
         argidx_q   <= argidx_d;
         pf_valid_q <= pf_valid_d;
         pf_index_q <= pf_index_d;
         pf_score_q <= pf_score_d;
         done_q     <= done_d;
         pf_count_q <= pf_count_d;
         argmax_q   <= argmax_d;
         overrun_q  <= overrun_d;
      end
   end

   assign pf_valid     = pf_valid_q;
   assign pf_index     = pf_index_q;
   assign pf_score     = pf_score_q;
   assign done         = done_q;
   assign pf_count     = pf_count_q;
   assign argmax_index = argmax_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_prefetch_select.sv
// tb/tb_prefetch_select.sv - directed and randomized bench for prefetch_select
// Build with or without ARGMAX_FALLBACK_EN.
module tb_prefetch_select;
   import lstm_pf_pkg::*;

   localparam int N     = 16;
   localparam int MAXPF = 4;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [N*BITWIDTH-1:0]  outputVec;
   logic                   data_result_Ready;
   logic [BITWIDTH-1:0]    threshold;
   logic                   pf_valid;
   logic                   pf_ready;
   logic [3:0]             pf_index;
   logic [BITWIDTH-1:0]    pf_score;
   logic                   done;
   logic [2:0]             pf_count;
   logic [3:0]             argmax_index;
   logic                   overrun;

   int total = 0;
   int bad   = 0;

   logic [BITWIDTH-1:0] lg [N];
   int                  exp_idx [$];
   logic [BITWIDTH-1:0] exp_sc [$];
   int                  exp_cnt;
   int                  exp_arg;

   always #5 clock = ~clock;

   prefetch_select #(.FINAL_OUT_SIZE(N), .MAX_PF(MAXPF)) dut (
      .clock             (clock),
      .reset             (reset),
      .outputVec         (outputVec),
      .data_result_Ready (data_result_Ready),
      .threshold         (threshold),
      .pf_valid          (pf_valid),
      .pf_ready          (pf_ready),
      .pf_index          (pf_index),
      .pf_score          (pf_score),
      .done              (done),
      .pf_count          (pf_count),
      .argmax_index      (argmax_index),
      .overrun           (overrun)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < N; i++) lg[i] = BITWIDTH'(v);
   endtask

   // reference: first MAX_PF indices above threshold, argmax over the scanned prefix
   task automatic model(input logic [BITWIDTH-1:0] th);
      int last;
      int best;
      exp_idx.delete();
      exp_sc.delete();
      last = N - 1;
      for (int i = 0; i < N; i++) begin
         if ($signed(lg[i]) > $signed(th)) begin
            exp_idx.push_back(i);
            exp_sc.push_back(lg[i]);
            if (exp_idx.size() == MAXPF) begin
               last = i;
               break;
            end
         end
      end
      best = 0;
      for (int i = 1; i <= last; i++)
         if ($signed(lg[i]) > $signed(lg[best])) best = i;
      exp_arg = best;
`ifdef ARGMAX_FALLBACK_EN
      if (exp_idx.size() == 0) begin
         exp_idx.push_back(best);
         exp_sc.push_back(lg[best]);
      end
`endif
      exp_cnt = exp_idx.size();
   endtask

   // mode 0: ready high, 1: random ready, 2: stall first beat 10 cycles
   task automatic run_vec(input string tag, input logic [BITWIDTH-1:0] th, input int mode,
                          input bit inject, input int exp_lat);
      int  c, beats, stall;
      bit  seen_done, ovr_pend, injected, in_beat;
      logic [3:0]          h_idx;
      logic [BITWIDTH-1:0] h_sc;
      model(th);
      for (int i = 0; i < N; i++) outputVec[i*BITWIDTH +: BITWIDTH] = lg[i];
      threshold = th;
      data_result_Ready = 1'b1;
      pf_ready = 1'b0;
      @(posedge clock); #1;
      data_result_Ready = 1'b0;
      c = 0; beats = 0; stall = 0;
      seen_done = 0; ovr_pend = 0; injected = 0; in_beat = 0;
      h_idx = '0; h_sc = '0;
      while (!seen_done && c < 300) begin
         @(posedge clock); #1;
         c++;
         chk({tag, " overrun"}, overrun, ovr_pend);
         ovr_pend = 0;
         data_result_Ready = 1'b0;
         if (done) begin
            seen_done = 1;
            chk({tag, " beats"}, beats, exp_cnt);
            chk({tag, " pf_count"}, pf_count, exp_cnt);
            chk({tag, " argmax"}, argmax_index, exp_arg);
            chk({tag, " valid at done"}, pf_valid, 0);
            if (exp_lat > 0) chk({tag, " done latency"}, c, exp_lat);
         end else if (pf_valid) begin
            if (!in_beat) begin
               in_beat = 1;
               h_idx = pf_index;
               h_sc = pf_score;
               if (beats < exp_cnt) begin
                  chk({tag, " beat idx"}, pf_index, exp_idx[beats]);
                  chk({tag, " beat score"}, pf_score, exp_sc[beats]);
               end else begin
                  chk({tag, " extra beat"}, beats + 1, exp_cnt);
               end
               stall = (mode == 2 && beats == 0) ? 10 : 0;
               if (inject && !injected) begin
                  data_result_Ready = 1'b1;
                  injected = 1;
                  ovr_pend = 1;
               end
            end else begin
               chk({tag, " hold idx"}, pf_index, h_idx);
               chk({tag, " hold score"}, pf_score, h_sc);
            end
            if (stall > 0) begin
               pf_ready = 1'b0;
               stall--;
            end else if (mode == 1) begin
               pf_ready = 1'($urandom_range(0, 1));
            end else begin
               pf_ready = 1'b1;
            end
            if (pf_ready) begin
               beats++;
               in_beat = 0;
            end
         end else begin
            pf_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      if (!seen_done) chk({tag, " done timeout"}, 0, 1);
      pf_ready = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
         chk({tag, " tail valid"}, pf_valid, 0);
         chk({tag, " tail done"}, done, 0);
      end
   endtask

   task automatic reset_in_hold();
      int w;
      int dones;
      fill(-2048);
      lg[5] = 18'h00800;
      for (int i = 0; i < N; i++) outputVec[i*BITWIDTH +: BITWIDTH] = lg[i];
      threshold = '0;
      pf_ready = 1'b0;
      data_result_Ready = 1'b1;
      @(posedge clock); #1;
      data_result_Ready = 1'b0;
      w = 0;
      while (!pf_valid && w < 40) begin
         @(posedge clock); #1;
         w++;
      end
      chk("rst hold valid seen", pf_valid, 1);
      chk("rst hold idx", pf_index, 5);
      #2 reset = 1'b1;
      #1;
      chk("rst async valid", pf_valid, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      dones = 0;
      repeat (30) begin
         @(posedge clock); #1;
         if (done || pf_valid) dones++;
      end
      chk("rst no done", dones, 0);
   endtask

   initial begin
      int lat1;
      reset = 1'b1;
      outputVec = '0;
      data_result_Ready = 1'b0;
      threshold = '0;
      pf_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset pf_valid", pf_valid, 0);
      chk("reset done", done, 0);
      chk("reset pf_count", pf_count, 0);
      chk("reset argmax", argmax_index, 0);
      chk("reset overrun", overrun, 0);
      chk("reset pf_index", pf_index, 0);
      chk("reset pf_score", pf_score, 0);
      reset = 1'b0;
      @(posedge clock); #1;

`ifdef ARGMAX_FALLBACK_EN
      lat1 = 0;
`else
      lat1 = N + 1;
`endif
      fill(-2048);
      run_vec("all_neg", '0, 0, 0, lat1);
`ifdef ARGMAX_FALLBACK_EN
      chk("all_neg const count", pf_count, 1);
`else
      chk("all_neg const count", pf_count, 0);
`endif
      chk("all_neg const argmax", argmax_index, 0);

      fill(0);
      lg[3] = 18'h00400;
      lg[9] = 18'h00800;
      run_vec("two_hits", '0, 0, 0, 0);
      chk("two_hits const count", pf_count, 2);
      chk("two_hits const argmax", argmax_index, 9);

      fill(2048);
      run_vec("cap", '0, 1, 0, 0);
      chk("cap const count", pf_count, 4);
      chk("cap const argmax", argmax_index, 0);

      fill(-2048);
      lg[5] = 18'h00c00;
      run_vec("stall", '0, 2, 0, 0);

      fill(0);
      lg[2] = 18'h00400;
      lg[11] = 18'h00400;
      run_vec("overrun", '0, 1, 1, 0);

`ifdef ARGMAX_FALLBACK_EN
      fill(-4096);
      lg[7] = 18'h3FC00;
      run_vec("fallback", '0, 0, 0, 0);
      chk("fallback const idx", pf_count, 1);
      chk("fallback const argmax", argmax_index, 7);
`endif

      reset_in_hold();

      for (int t = 0; t < 25; t++) begin
         logic [BITWIDTH-1:0] th;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) lg[i] = BITWIDTH'($urandom);
            else lg[i] = BITWIDTH'((int'($urandom_range(0, 8)) - 4) * 1024);
         end
         th = BITWIDTH'((int'($urandom_range(0, 6)) - 3) * 1024);
         run_vec("rand", th, int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
